// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared types and constants for the PC sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    // Sequencer state; REDIRECT is the one-cycle wrong-path kill slot
    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    // Byte distance between consecutive instruction words
    localparam logic [31:0] PC_INCR = 32'd4;

    // Sign-extend a word-unit branch offset and convert it to a byte offset
    function automatic logic [31:0] branch_byte_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_gen.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_gen
//  Description : Combinational sequential / branch / jump target generation.
//                All additions wrap modulo 2^32.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_gen
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    output logic [31:0] seq_target,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target
);

    // Branch offsets are relative to the delay-slot address, jumps keep its region
    assign seq_target    = pc + PC_INCR;
    assign branch_target = seq_target + branch_byte_offset(branch_imm);
    assign jump_target   = {seq_target[31:28], jump_index, 2'b00};

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter owner for the single-issue MIPS core. Issues
//                fetch addresses with a ready handshake and applies
//                sequential / branch / jump redirects.
//                Build macro BRANCH_DELAY_SLOT_EN: taken redirects are deferred
//                by one fetch (delay slot executed, no flush). Undefined: the
//                redirect is immediate and the wrong-path fetch is flushed.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_req,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump_req,
    input  logic [25:0] jump_index,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] pc_plus4,
    output logic        redirect_ack,
    output logic        flush
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;

    logic [31:0] w_seq_target;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_redir_target;
    logic        w_advance;
    logic        w_take;
    logic        w_ack;

    branch_target_gen u_target_gen (
        .pc            (pc_q),
        .branch_imm    (branch_imm),
        .jump_index    (jump_index),
        .seq_target    (w_seq_target),
        .branch_target (w_branch_target),
        .jump_target   (w_jump_target)
    );

    // Stall dominates the imem handshake; nothing moves outside FETCH
    assign w_advance      = (state_q == FETCH) && imem_ready && !stall;
    assign w_take         = jump_req || (branch_req && branch_taken);
    assign w_redir_target = jump_req ? w_jump_target : w_branch_target;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pending_q, pending_d;
    logic [31:0] pend_target_q, pend_target_d;

    // Next-state: a taken redirect first fetches the delay slot, then the target
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        pend_target_d = pend_target_q;
        w_ack         = 1'b0;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (w_advance) begin
                    if (pending_q) begin
                        pc_d      = pend_target_q;
                        pending_d = 1'b0;
                    end else begin
                        w_ack = jump_req || branch_req;
                        pc_d  = w_seq_target;
                        if (w_take) begin
                            pending_d     = 1'b1;
                            pend_target_d = w_redir_target;
                        end
                    end
                end
            end
            default: state_d = FETCH;
        endcase
        pc_valid_d = (state_d == FETCH);
    end

    // State, PC and pending-target registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            pc_valid_q    <= 1'b0;
            pending_q     <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            pending_q     <= pending_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign flush = 1'b0;
`else
    logic flush_q, flush_d;

    // Next-state: a taken redirect loads the target and spends one cycle flushing
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        w_ack   = 1'b0;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (w_advance) begin
                    w_ack = jump_req || branch_req;
                    if (w_take) begin
                        pc_d    = w_redir_target;
                        state_d = REDIRECT;
                    end else begin
                        pc_d = w_seq_target;
                    end
                end
            end
            REDIRECT: state_d = FETCH;
            default:  state_d = BOOT;
        endcase
        pc_valid_d = (state_d == FETCH);
        flush_d    = (state_d == REDIRECT);
    end

    // State, PC and registered fetch-control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
        end
    end

    assign flush = flush_q;
`endif

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign pc_plus4     = w_seq_target;
    assign redirect_ack = w_ack;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. One row per clock
//                cycle: inputs plus the outputs expected during that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic        tk;
        logic [15:0] imm;
        logic        jr;
        logic [25:0] idx;
        logic        rdy;
        logic        chk;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        ack;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_req = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = 16'd0;
    logic        jump_req = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic        imem_ready = 1'b0;

    logic [31:0] pc, pc_plus4, pc_b, pc_plus4_b;
    logic        pc_valid, redirect_ack, flush;
    logic        pc_valid_b, redirect_ack_b, flush_b;

    int checks = 0;
    int failures = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    // Main DUT: reset vector near the top of memory so wrap and region tests are reachable
    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF0)) dut (
        .clk          (clk),
        .reset        (rst),
        .stall        (stall),
        .branch_req   (branch_req),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump_req     (jump_req),
        .jump_index   (jump_index),
        .imem_ready   (imem_ready),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .pc_plus4     (pc_plus4),
        .redirect_ack (redirect_ack),
        .flush        (flush)
    );

    // Second DUT: free-running sequential fetch from 0x0040_0000
    pc_sequencer #(.RESET_VECTOR(32'h0040_0000)) dut_b (
        .clk          (clk),
        .reset        (rst),
        .stall        (1'b0),
        .branch_req   (1'b0),
        .branch_taken (1'b0),
        .branch_imm   (16'd0),
        .jump_req     (1'b0),
        .jump_index   (26'd0),
        .imem_ready   (1'b1),
        .pc           (pc_b),
        .pc_valid     (pc_valid_b),
        .pc_plus4     (pc_plus4_b),
        .redirect_ack (redirect_ack_b),
        .flush        (flush_b)
    );

    task automatic add(input logic r, input logic s, input logic b, input logic t,
                       input logic [15:0] im, input logic j, input logic [25:0] ix,
                       input logic rd, input logic c, input logic [31:0] p,
                       input logic v, input logic f, input logic a);
        vec_t e;
        e.rst = r; e.stall = s; e.br = b; e.tk = t; e.imm = im; e.jr = j;
        e.idx = ix; e.rdy = rd; e.chk = c; e.pc = p; e.valid = v; e.flush = f; e.ack = a;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask

    initial begin
        vec_t d, e;
        logic [31:0] exp_b_pc;

        // rst stall br tk imm jr idx rdy | chk pc valid flush ack
        add(1, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 0, 32'h0,         0, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hFFFF_FFF0, 0, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hFFFF_FFF0, 1, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hFFFF_FFF4, 1, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hFFFF_FFF8, 1, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hFFFF_FFFC, 1, 0, 0);
`ifdef BRANCH_DELAY_SLOT_EN
        add(0, 0, 0, 0, 16'h0000, 1, 26'h80, 1, 1, 32'h0000_0000, 1, 0, 1);
        add(0, 0, 1, 1, 16'h0010, 0, 26'h0,  1, 1, 32'h0000_0004, 1, 0, 0);
        add(0, 0, 1, 1, 16'h0004, 0, 26'h0,  1, 1, 32'h0000_0200, 1, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'h0000_0204, 1, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'h0000_0214, 1, 0, 0);
`else
        add(0, 0, 0, 0, 16'h0000, 1, 26'h40, 1, 1, 32'h0000_0000, 1, 0, 1);
        add(0, 0, 1, 1, 16'hFFFF, 0, 26'h0,  1, 1, 32'h0000_0100, 0, 1, 0);
        add(0, 0, 1, 1, 16'hFFFF, 0, 26'h0,  1, 1, 32'h0000_0100, 1, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'h0000_0100, 0, 1, 0);
        add(0, 0, 1, 0, 16'hFFFF, 0, 26'h0,  1, 1, 32'h0000_0100, 1, 0, 1);
        add(0, 0, 1, 1, 16'h0010, 0, 26'h0,  0, 1, 32'h0000_0104, 1, 0, 0);
        add(0, 0, 1, 1, 16'h0010, 0, 26'h0,  0, 1, 32'h0000_0104, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0010, 0, 26'h0,  1, 1, 32'h0000_0104, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0010, 0, 26'h0,  1, 1, 32'h0000_0104, 1, 0, 0);
        add(0, 1, 1, 1, 16'h0010, 0, 26'h0,  1, 1, 32'h0000_0104, 1, 0, 0);
        add(0, 0, 1, 1, 16'h0010, 0, 26'h0,  1, 1, 32'h0000_0104, 1, 0, 1);
        add(0, 1, 0, 0, 16'h0000, 0, 26'h0,  0, 1, 32'h0000_0148, 0, 1, 0);
        add(0, 1, 0, 0, 16'h0000, 1, 26'h80, 0, 1, 32'h0000_0148, 1, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 26'h80, 1, 1, 32'h0000_0148, 1, 0, 1);
        add(1, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'h0000_0200, 0, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hFFFF_FFF0, 0, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 26'h4,  1, 1, 32'hFFFF_FFF0, 1, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hF000_0010, 0, 1, 0);
        add(0, 0, 1, 1, 16'h0008, 1, 26'h40, 1, 1, 32'hF000_0010, 1, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hF000_0100, 0, 1, 0);
        add(0, 1, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hF000_0100, 1, 0, 0);
        add(1, 1, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hF000_0100, 1, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hFFFF_FFF0, 0, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 26'h0,  1, 1, 32'hFFFF_FFF0, 1, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            d = vecs[i];
            rst          = d.rst;
            stall        = d.stall;
            branch_req   = d.br;
            branch_taken = d.tk;
            branch_imm   = d.imm;
            jump_req     = d.jr;
            jump_index   = d.idx;
            imem_ready   = d.rdy;
            exp_q.push_back(d);
            #2;
            e = exp_q.pop_front();
            if (e.chk) begin
                check("pc",           i, pc,                    e.pc);
                check("pc_valid",     i, {31'd0, pc_valid},     {31'd0, e.valid});
                check("flush",        i, {31'd0, flush},        {31'd0, e.flush});
                check("redirect_ack", i, {31'd0, redirect_ack}, {31'd0, e.ack});
                check("pc_plus4",     i, pc_plus4,              e.pc + 32'd4);
            end
            // Sequential fetch from the 0x0040_0000 reset vector after the first reset
            if (i >= 1 && i <= 4) begin
                exp_b_pc = 32'h0040_0000 + ((i >= 2) ? 32'(4 * (i - 2)) : 32'd0);
                check("seq_pc",       i, pc_b,                exp_b_pc);
                check("seq_pc_valid", i, {31'd0, pc_valid_b}, {31'd0, (i >= 2)});
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
